// File: rtl/ex_stage_pkg.sv
// Shared constants for the RV32I(M) execute stage: opcodes, funct3/funct7 encodings,
// divider state encoding and a small magnitude helper.
package ex_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  localparam logic [6:0] FUNC7_M = 7'b0000001;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Restoring divider for RV32M: IDLE -> BUSY (DIV_CYCLES iterations) -> DONE -> IDLE.
// Operates on magnitudes and applies the sign correction to the result.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  quo, rem, dvs;
  logic             neg_q, neg_r, rem_sel;
  logic [XLEN:0]    trial, diff;

  // Shift in the next dividend bit and try to subtract the divisor.
  assign trial = {rem, quo[XLEN-1]};
  assign diff  = trial - {1'b0, dvs};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      quo     <= '0;
      rem     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_sel <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            quo     <= abs_val(dividend, is_signed);
            dvs     <= abs_val(divisor, is_signed);
            rem     <= '0;
            neg_q   <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            neg_r   <= is_signed && dividend[XLEN-1];
            rem_sel <= is_rem;
            cnt     <= '0;
            state   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          if (diff[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
          end else begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  // The accepting IDLE cycle already stalls; reset drops the stall at once.
  assign busy   = !rst && ((state == DIV_BUSY) || ((state == DIV_IDLE) && start));
  assign done   = (state == DIV_DONE);
  assign result = rem_sel ? (neg_r ? (~rem + 1'b1) : rem)
                          : (neg_q ? (~quo + 1'b1) : quo);

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the RV32I(M) pipeline. Define RV32M_EN to add the multiplier and
// the stalling divider; without it, M-extension ops retire as NOPs.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      func3_in,
  input  logic [6:0]      func7_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            rd_en_in,
  input  logic [4:0]      rd_addr_in,
  input  logic [31:0]     imm_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  output logic            rd_en_out,
  output logic [4:0]      rd_addr_out,
  output logic [XLEN-1:0] rd_wdata_out,
  output logic            mem_re_out,
  output logic            mem_we_out,
  output logic [XLEN-1:0] mem_addr_out,
  output logic [XLEN-1:0] mem_wdata_out,
  output logic [2:0]      mem_func3_out,
  output logic            jump_flag_out,
  output logic [XLEN-1:0] jump_addr_out,
  output logic            ex_stall_out
);

  logic signed [XLEN-1:0] rs1_s, rs2_s, op_b_s;
  logic [XLEN-1:0] op_b, alu_res, rs1_imm, pc_imm, pc_4;
  logic [4:0]      shamt;
  logic            alt, taken, rd_en_int;
  logic            m_en;
  logic [XLEN-1:0] m_wdata;

  assign op_b    = (opcode_in == OP) ? rs2_in : imm_in;
  assign rs1_s   = rs1_in;
  assign rs2_s   = rs2_in;
  assign op_b_s  = op_b;
  assign shamt   = op_b[4:0];
  assign alt     = (opcode_in == OP) ? func7_in[5] : imm_in[10];
  assign rs1_imm = rs1_in + imm_in;
  assign pc_imm  = pc_in + imm_in;
  assign pc_4    = pc_in + 32'd4;

  always_comb begin
    alu_res = '0;
    case (func3_in)
      F3_ADD_SUB: alu_res = ((opcode_in == OP) && func7_in[5]) ? (rs1_in - op_b) : (rs1_in + op_b);
      F3_SLL:     alu_res = rs1_in << shamt;
      F3_SLT:     alu_res = {{(XLEN-1){1'b0}}, rs1_s < op_b_s};
      F3_SLTU:    alu_res = {{(XLEN-1){1'b0}}, rs1_in < op_b};
      F3_XOR:     alu_res = rs1_in ^ op_b;
      F3_SRL_SRA: alu_res = alt ? XLEN'(rs1_s >>> shamt) : (rs1_in >> shamt);
      F3_OR:      alu_res = rs1_in | op_b;
      F3_AND:     alu_res = rs1_in & op_b;
      default:    alu_res = '0;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (func3_in)
      F3_BEQ:  taken = (rs1_in == rs2_in);
      F3_BNE:  taken = (rs1_in != rs2_in);
      F3_BLT:  taken = (rs1_s < rs2_s);
      F3_BGE:  taken = (rs1_s >= rs2_s);
      F3_BLTU: taken = (rs1_in < rs2_in);
      F3_BGEU: taken = (rs1_in >= rs2_in);
      default: taken = 1'b0;
    endcase
  end

`ifdef RV32M_EN
  logic signed [2*XLEN-1:0] mul_a, mul_b, mul_p;
  logic [XLEN-1:0] mul_res, div_res, div_special;
  logic            is_div, div_zero, div_ovf, div_start, div_busy, div_done;

  assign mul_a   = {{XLEN{(func3_in != F3_MULHU) && rs1_in[XLEN-1]}}, rs1_in};
  assign mul_b   = {{XLEN{((func3_in == F3_MUL) || (func3_in == F3_MULH)) && rs2_in[XLEN-1]}}, rs2_in};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (func3_in == F3_MUL) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];

  // Divide-by-zero and signed overflow resolve in one cycle without the FSM.
  assign is_div      = (opcode_in == OP) && (func7_in == FUNC7_M) && func3_in[2];
  assign div_zero    = (rs2_in == '0);
  assign div_ovf     = !func3_in[0] && (rs1_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_in == '1);
  assign div_start   = is_div && !div_zero && !div_ovf;
  assign div_special = func3_in[1] ? (div_zero ? rs1_in : '0)
                                   : (div_zero ? '1 : rs1_in);

  ex_div #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (!func3_in[0]),
    .is_rem    (func3_in[1]),
    .dividend  (rs1_in),
    .divisor   (rs2_in),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_res)
  );

  assign m_en         = !func3_in[2] || !div_start || div_done;
  assign m_wdata      = !func3_in[2] ? mul_res :
                        (div_start ? (div_done ? div_res : '0) : div_special);
  assign ex_stall_out = div_busy;
`else
  assign m_en         = 1'b0;
  assign m_wdata      = '0;
  assign ex_stall_out = 1'b0;
`endif

  always_comb begin
    rd_en_int     = 1'b0;
    rd_wdata_out  = '0;
    mem_re_out    = 1'b0;
    mem_we_out    = 1'b0;
    mem_addr_out  = '0;
    mem_wdata_out = '0;
    mem_func3_out = '0;
    jump_flag_out = 1'b0;
    jump_addr_out = '0;
    case (opcode_in)
      OP: begin
        if (func7_in == FUNC7_M) begin
          rd_en_int    = m_en;
          rd_wdata_out = m_wdata;
        end else begin
          rd_en_int    = 1'b1;
          rd_wdata_out = alu_res;
        end
      end
      OP_IMM: begin
        rd_en_int    = 1'b1;
        rd_wdata_out = alu_res;
      end
      LUI: begin
        rd_en_int    = 1'b1;
        rd_wdata_out = imm_in;
      end
      AUIPC: begin
        rd_en_int    = 1'b1;
        rd_wdata_out = pc_imm;
      end
      JAL: begin
        rd_en_int     = 1'b1;
        rd_wdata_out  = pc_4;
        jump_flag_out = 1'b1;
        jump_addr_out = pc_imm;
      end
      JALR: begin
        rd_en_int     = 1'b1;
        rd_wdata_out  = pc_4;
        jump_flag_out = 1'b1;
        jump_addr_out = {rs1_imm[XLEN-1:1], 1'b0};
      end
      BRANCH: begin
        jump_flag_out = taken;
        jump_addr_out = taken ? pc_imm : '0;
      end
      LOAD: begin
        rd_en_int     = 1'b1;
        mem_re_out    = 1'b1;
        mem_addr_out  = rs1_imm;
        mem_func3_out = func3_in;
      end
      STORE: begin
        mem_we_out    = 1'b1;
        mem_addr_out  = rs1_imm;
        mem_wdata_out = rs2_in;
        mem_func3_out = func3_in;
      end
      default: ;
    endcase
  end

  assign rd_en_out   = rd_en_int && rd_en_in && (rd_addr_in != 5'd0);
  assign rd_addr_out = (opcode_in == 7'd0) ? 5'd0 : rd_addr_in;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage with hand-computed expectations; the M-extension checks
// follow the RV32M_EN build option.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      opcode_in, func7_in;
  logic [2:0]      func3_in;
  logic [31:0]     pc_in, imm_in, rs1_in, rs2_in;
  logic            rd_en_in;
  logic [4:0]      rd_addr_in;
  logic            rd_en_out, mem_re_out, mem_we_out, jump_flag_out, ex_stall_out;
  logic [4:0]      rd_addr_out;
  logic [31:0]     rd_wdata_out, mem_addr_out, mem_wdata_out, jump_addr_out;
  logic [2:0]      mem_func3_out;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stall;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .opcode_in     (opcode_in),
    .func3_in      (func3_in),
    .func7_in      (func7_in),
    .pc_in         (pc_in),
    .rd_en_in      (rd_en_in),
    .rd_addr_in    (rd_addr_in),
    .imm_in        (imm_in),
    .rs1_in        (rs1_in),
    .rs2_in        (rs2_in),
    .rd_en_out     (rd_en_out),
    .rd_addr_out   (rd_addr_out),
    .rd_wdata_out  (rd_wdata_out),
    .mem_re_out    (mem_re_out),
    .mem_we_out    (mem_we_out),
    .mem_addr_out  (mem_addr_out),
    .mem_wdata_out (mem_wdata_out),
    .mem_func3_out (mem_func3_out),
    .jump_flag_out (jump_flag_out),
    .jump_addr_out (jump_addr_out),
    .ex_stall_out  (ex_stall_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    opcode_in  = opc;
    func3_in   = f3;
    func7_in   = f7;
    pc_in      = pc;
    imm_in     = imm;
    rs1_in     = a;
    rs2_in     = b;
    rd_addr_in = rd;
    #1;
  endtask

  // Counts consecutive stalled cycles, starting with the current one.
  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!ex_stall_out) break;
      n++;
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode_in = '0; func3_in = '0; func7_in = '0; pc_in = '0; imm_in = '0;
    rs1_in = '0; rs2_in = '0; rd_en_in = 1'b1; rd_addr_in = '0;
    @(negedge clk);
    #1;
    check("reset_stall", {31'd0, ex_stall_out}, 32'd0);
    check("reset_rd_en", {31'd0, rd_en_out}, 32'd0);
    check("reset_wdata", rd_wdata_out, 32'd0);
    rst = 1'b0;

    drive(OP, 3'b000, 7'h00, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h1, 5'd5);
    check("add_wdata", rd_wdata_out, 32'h80000000);
    check("add_rd_en", {31'd0, rd_en_out}, 32'd1);
    check("add_rd_addr", {27'd0, rd_addr_out}, 32'd5);
    check("add_stall", {31'd0, ex_stall_out}, 32'd0);

    drive(OP, 3'b000, 7'h20, 32'h0, 32'h0, 32'd5, 32'd7, 5'd5);
    check("sub_wdata", rd_wdata_out, 32'hFFFFFFFE);
    drive(OP_IMM, 3'b101, 7'h00, 32'h0, 32'h404, 32'h80000000, 32'h0, 5'd5);
    check("srai_wdata", rd_wdata_out, 32'hF8000000);
    drive(OP_IMM, 3'b101, 7'h00, 32'h0, 32'h004, 32'h80000000, 32'h0, 5'd5);
    check("srli_wdata", rd_wdata_out, 32'h08000000);
    drive(OP, 3'b010, 7'h00, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd1, 5'd5);
    check("slt_wdata", rd_wdata_out, 32'd1);
    drive(OP, 3'b011, 7'h00, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd1, 5'd5);
    check("sltu_wdata", rd_wdata_out, 32'd0);
    drive(OP, 3'b001, 7'h00, 32'h0, 32'h0, 32'd1, 32'h00000025, 5'd5);
    check("sll_wdata", rd_wdata_out, 32'h00000020);
    drive(OP, 3'b000, 7'h00, 32'h0, 32'h0, 32'd1, 32'd2, 5'd0);
    check("x0_rd_en", {31'd0, rd_en_out}, 32'd0);

    drive(BRANCH, 3'b000, 7'h00, 32'h100, 32'h20, 32'd5, 32'd5, 5'd0);
    check("beq_jump", {31'd0, jump_flag_out}, 32'd1);
    check("beq_addr", jump_addr_out, 32'h120);
    check("beq_rd_en", {31'd0, rd_en_out}, 32'd0);
    drive(BRANCH, 3'b000, 7'h00, 32'h100, 32'h20, 32'd5, 32'd6, 5'd0);
    check("beq_nt_jump", {31'd0, jump_flag_out}, 32'd0);
    drive(BRANCH, 3'b100, 7'h00, 32'h100, 32'h40, 32'hFFFFFFFF, 32'd1, 5'd0);
    check("blt_jump", {31'd0, jump_flag_out}, 32'd1);

    drive(JALR, 3'b000, 7'h00, 32'h200, 32'h0, 32'h301, 32'h0, 5'd1);
    check("jalr_addr", jump_addr_out, 32'h300);
    check("jalr_wdata", rd_wdata_out, 32'h204);
    check("jalr_jump", {31'd0, jump_flag_out}, 32'd1);
    drive(JAL, 3'b000, 7'h00, 32'h200, 32'hFFFFFFF0, 32'h0, 32'h0, 5'd1);
    check("jal_addr", jump_addr_out, 32'h1F0);

    drive(LUI, 3'b000, 7'h00, 32'h0, 32'h12345000, 32'h0, 32'h0, 5'd3);
    check("lui_wdata", rd_wdata_out, 32'h12345000);
    drive(AUIPC, 3'b000, 7'h00, 32'h100, 32'h1000, 32'h0, 32'h0, 5'd3);
    check("auipc_wdata", rd_wdata_out, 32'h1100);

    drive(LOAD, 3'b010, 7'h00, 32'h0, 32'h8, 32'h1000, 32'h0, 5'd4);
    check("lw_re", {31'd0, mem_re_out}, 32'd1);
    check("lw_addr", mem_addr_out, 32'h1008);
    check("lw_wdata", rd_wdata_out, 32'd0);
    drive(STORE, 3'b001, 7'h00, 32'h0, 32'hFFFFFFFC, 32'h1000, 32'hABCD, 5'd4);
    check("sh_we", {31'd0, mem_we_out}, 32'd1);
    check("sh_rd_en", {31'd0, rd_en_out}, 32'd0);
    check("sh_mem_wdata", mem_wdata_out, 32'hABCD);
    check("sh_func3", {29'd0, mem_func3_out}, 32'd1);

    drive(7'd0, 3'b000, 7'h00, 32'h100, 32'h20, 32'd5, 32'd5, 5'd5);
    check("bubble_rd_en", {31'd0, rd_en_out}, 32'd0);
    check("bubble_jump", {31'd0, jump_flag_out}, 32'd0);
    check("bubble_rd_addr", {27'd0, rd_addr_out}, 32'd0);

`ifdef RV32M_EN
    drive(OP, F3_MULHU, FUNC7_M, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6);
    check("mulhu_wdata", rd_wdata_out, 32'hFFFFFFFE);
    drive(OP, F3_MUL, FUNC7_M, 32'h0, 32'h0, 32'd3, 32'hFFFFFFFE, 5'd6);
    check("mul_wdata", rd_wdata_out, 32'hFFFFFFFA);
    drive(OP, F3_MULHSU, FUNC7_M, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd2, 5'd6);
    check("mulhsu_wdata", rd_wdata_out, 32'hFFFFFFFF);

    drive(OP, 3'b100, FUNC7_M, 32'h0, 32'h0, 32'hFFFFFFF9, 32'd2, 5'd7);
    count_stall(n_stall);
    check("div_stall_cycles", n_stall, 32'd33);
    check("div_wdata", rd_wdata_out, 32'hFFFFFFFD);
    check("div_rd_en", {31'd0, rd_en_out}, 32'd1);
    drive(OP, 3'b110, FUNC7_M, 32'h0, 32'h0, 32'hFFFFFFF9, 32'd2, 5'd7);
    count_stall(n_stall);
    check("rem_stall_cycles", n_stall, 32'd33);
    check("rem_wdata", rd_wdata_out, 32'hFFFFFFFF);

    drive(OP, 3'b101, FUNC7_M, 32'h0, 32'h0, 32'd9, 32'd0, 5'd7);
    check("divu0_stall", {31'd0, ex_stall_out}, 32'd0);
    check("divu0_wdata", rd_wdata_out, 32'hFFFFFFFF);
    drive(OP, 3'b111, FUNC7_M, 32'h0, 32'h0, 32'd9, 32'd0, 5'd7);
    check("remu0_wdata", rd_wdata_out, 32'd9);
    drive(OP, 3'b100, FUNC7_M, 32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 5'd7);
    check("divovf_stall", {31'd0, ex_stall_out}, 32'd0);
    check("divovf_wdata", rd_wdata_out, 32'h80000000);
    drive(OP, 3'b110, FUNC7_M, 32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 5'd7);
    check("removf_wdata", rd_wdata_out, 32'd0);

    drive(OP, 3'b101, FUNC7_M, 32'h0, 32'h0, 32'd100, 32'd7, 5'd7);
    repeat (10) @(negedge clk);
    #1;
    check("divu_busy_stall", {31'd0, ex_stall_out}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("divu_rst_stall", {31'd0, ex_stall_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    count_stall(n_stall);
    check("divu_stall_cycles", n_stall, 32'd33);
    check("divu_wdata", rd_wdata_out, 32'd14);
`else
    drive(OP, 3'b100, FUNC7_M, 32'h0, 32'h0, 32'hFFFFFFF9, 32'd2, 5'd7);
    check("nom_div_stall", {31'd0, ex_stall_out}, 32'd0);
    check("nom_div_rd_en", {31'd0, rd_en_out}, 32'd0);
    drive(OP, F3_MUL, FUNC7_M, 32'h0, 32'h0, 32'd3, 32'd4, 5'd6);
    check("nom_mul_rd_en", {31'd0, rd_en_out}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
